nubus_mem_target: RTL and testbench

NUBUS_MEM_TARGET -- requirements
Module: nubus_mem_target

---
 rtl/nubus_pkg.sv | 15 +
 rtl/nubus_mem_target_if.sv | 23 ++
 rtl/nubus_mem_array.sv | 40 ++++
 rtl/nubus_mem_target.sv | 99 +++++++++
 tb/tb_nubus_mem_target.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/nubus_pkg.sv
// Shared types and widths for the NuBus memory target.
package nubus_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        HOLD
    } state_e;

endpackage

// File: rtl/nubus_mem_target_if.sv
// Card-side access channel between the bus interface (master) and the memory target (slave).
interface nubus_mem_target_if;
    import nubus_pkg::*;

    logic                 mem_valid;
    logic                 mem_myslot;
    logic [WORD_W-1:0]    mem_addr;
    logic [WORD_W-1:0]    mem_wdata;
    logic [LANES-1:0]     mem_write;
    logic                 mem_ready;
    logic [WORD_W-1:0]    mem_rdata;

    modport master (
        output mem_valid, mem_myslot, mem_addr, mem_wdata, mem_write,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_myslot, mem_addr, mem_wdata, mem_write,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/nubus_mem_array.sv
// Single-port synchronous word array, one byte-wide bank per lane; read data is registered and held.
module nubus_mem_array
    import nubus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en_i,
    input  logic [LANES-1:0]      we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [BYTE_W-1:0] mem_q [0:DEPTH-1];
        logic [BYTE_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i[l]) begin
                mem_q[addr_i] <= wdata_i[BYTE_W*l +: BYTE_W];
            end
        end

        // Output register only moves on reads, so a write leaves the last read word visible.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (rd_en_i) begin
                rd_q <= mem_q[addr_i];
            end
        end

        assign rdata_o[BYTE_W*l +: BYTE_W] = rd_q;
    end

endmodule

// File: rtl/nubus_mem_target.sv
// NuBus card memory target: request FSM with programmable wait states over nubus_mem_array.
// Define NUBUS_MEM_WPROT_EN to make the top ROM_WORDS words read-only (writes still acknowledged).
module nubus_mem_target
    import nubus_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1,
    parameter int ROM_WORDS   = 64
) (
    input  logic              nub_clk,
    input  logic              nub_reset,
    nubus_mem_target_if.slave mem
);

`ifdef NUBUS_MEM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    localparam logic [31:0] PROT_BASE = 32'((1 << DEPTH_LOG2) - ROM_WORDS);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  ready_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [LANES-1:0]      we_q;

    logic                  access;
    logic                  prot;
    logic                  arr_rd;
    logic [LANES-1:0]      arr_we;
    logic [WORD_W-1:0]     arr_rdata;

    // Gate on reset so an access caught by reset never reaches the array.
    assign access = (state_q == ACCESS) && !nub_reset;
    assign prot   = WPROT && (32'(idx_q) >= PROT_BASE);
    assign arr_rd = access && (we_q == '0);
    assign arr_we = access ? (we_q & {LANES{!prot}}) : '0;

    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem.mem_valid && mem.mem_myslot) begin
                        idx_q   <= mem.mem_addr[DEPTH_LOG2+1:2];
                        wdata_q <= mem.mem_wdata;
                        we_q    <= mem.mem_write;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (!mem.mem_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    ready_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!mem.mem_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    nubus_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (nub_clk),
        .rst     (nub_reset),
        .rd_en_i (arr_rd),
        .we_i    (arr_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = arr_rdata;

endmodule

// File: tb/tb_nubus_mem_target.sv
// Self-checking bench: dut0 has one wait state, dut1 has three; checked against a word-array model.
module tb_nubus_mem_target;
    import nubus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nubus_mem_target_if if0();
    nubus_mem_target_if if1();

    nubus_mem_target #(.DEPTH_LOG2(10), .WAIT_STATES(1), .ROM_WORDS(64)) dut0 (
        .nub_clk(clk), .nub_reset(rst), .mem(if0)
    );
    nubus_mem_target #(.DEPTH_LOG2(10), .WAIT_STATES(3), .ROM_WORDS(64)) dut1 (
        .nub_clk(clk), .nub_reset(rst), .mem(if1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic s, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] we);
        if (d == 0) begin
            if0.mem_valid = v; if0.mem_myslot = s; if0.mem_addr = a;
            if0.mem_wdata = wd; if0.mem_write = we;
        end else begin
            if1.mem_valid = v; if1.mem_myslot = s; if1.mem_addr = a;
            if1.mem_wdata = wd; if1.mem_write = we;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? if0.mem_ready : if1.mem_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? if0.mem_rdata : if1.mem_rdata;
    endfunction

    // Holds the request for at least hold_cyc edges, records latency, data and pulse count.
    task automatic do_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] we, input int hold_cyc,
                             output int lat, output logic [31:0] rd, output int pulses);
        lat = -1; rd = '0; pulses = 0;
        drive(d, 1'b1, 1'b1, a, wd, we);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (get_ready(d)) begin
                pulses++;
                if (lat < 0) begin lat = c; rd = get_rdata(d); end
            end
            if (lat >= 0 && c >= hold_cyc) break;
        end
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) begin
            @(posedge clk); #1;
            if (get_ready(d)) pulses++;
        end
    endtask

    logic [31:0] model [16];

    initial begin
        int lat, pulses, cnt;
        logic [31:0] rd, exp_rd, a, wd;
        logic [3:0] we;
        int idx;

        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready dut0", {31'b0, if0.mem_ready}, 32'h0);
        chk("reset rdata dut0", if0.mem_rdata, 32'h0);
        chk("reset ready dut1", {31'b0, if1.mem_ready}, 32'h0);
        chk("reset rdata dut1", if1.mem_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
        tbl[1]  = '{32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[2]  = '{32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF};
        tbl[3]  = '{32'h0000_0020, 32'h0000_00AA, 4'h1, 32'hDEAD_BEEF};
        tbl[4]  = '{32'h0000_0020, 32'h0,         4'h0, 32'h1122_33AA};
        tbl[5]  = '{32'h0000_0024, 32'hA5A5_A5A5, 4'hF, 32'h1122_33AA};
        tbl[6]  = '{32'h0000_0024, 32'h0000_BB00, 4'h2, 32'h1122_33AA};
        tbl[7]  = '{32'h0000_0024, 32'h0,         4'h0, 32'hA5A5_BBA5};
        tbl[8]  = '{32'h0000_0024, 32'hCC00_0000, 4'h8, 32'hA5A5_BBA5};
        tbl[9]  = '{32'h0000_0024, 32'h0,         4'h0, 32'hCCA5_BBA5};
        tbl[10] = '{32'h0000_1010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[11] = '{32'hFFFF_F024, 32'h1234_5678, 4'h5, 32'hDEAD_BEEF};
        tbl[12] = '{32'h0000_0024, 32'h0,         4'h0, 32'hCC34_BB78};

        for (int i = 0; i < 13; i++) begin
            do_access(0, tbl[i].addr, tbl[i].wdata, tbl[i].we, 3, lat, rd, pulses);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d pulses", i), 32'(pulses), 32'd1);
        end

        // Randomized traffic against a plain word-array model, addresses aliased via upper bits.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            do_access(0, 32'(i) << 2, model[i], 4'hF, 3, lat, rd, pulses);
        end
        do_access(0, 32'h0, 32'h0, 4'h0, 3, lat, rd, pulses);
        exp_rd = model[0];
        chk("rand baseline", rd, exp_rd);
        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, 15);
            a   = ($urandom & ~32'h0000_0FFC) | (32'(idx) << 2);
            wd  = $urandom;
            we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_access(0, a, wd, we, $urandom_range(3, 6), lat, rd, pulses);
            if (we == 4'h0) begin
                exp_rd = model[idx];
            end else begin
                for (int l = 0; l < 4; l++)
                    if (we[l]) model[idx][8*l +: 8] = wd[8*l +: 8];
            end
            chk($sformatf("rand%0d rdata a=%h we=%h", i, a, we), rd, exp_rd);
            chk($sformatf("rand%0d latency", i), 32'(lat), 32'd3);
        end

        // Not selected: valid without myslot must be ignored, then a real read is served normally.
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (if0.mem_ready) cnt++;
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("myslot0 no ready", 32'(cnt), 32'd0);
        do_access(0, 32'h0000_0010, 32'h0, 4'h0, 3, lat, rd, pulses);
        chk("myslot0 then read latency", 32'(lat), 32'd3);
        chk("myslot0 then read data", rd, model[4]);

        // Write-protected top region versus last writable word.
        do_access(0, 32'(1000) << 2, 32'h1234_5678, 4'hF, 3, lat, rd, pulses);
        chk("wprot write ack latency", 32'(lat), 32'd3);
        do_access(0, 32'(1000) << 2, 32'h0, 4'h0, 3, lat, rd, pulses);
`ifdef NUBUS_MEM_WPROT_EN
        n_chk++;
        if (rd === 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wprot word1000: got %h, expected any value but 12345678", rd);
        end
`else
        chk("no-wprot word1000", rd, 32'h1234_5678);
`endif
        do_access(0, 32'(959) << 2, 32'h1234_5678, 4'hF, 3, lat, rd, pulses);
        do_access(0, 32'(959) << 2, 32'h0, 4'h0, 3, lat, rd, pulses);
        chk("word959 stored", rd, 32'h1234_5678);

        // Three wait states: latency 5, one pulse over a 10-cycle hold.
        do_access(1, 32'h0000_0080, 32'h1111_1111, 4'hF, 3, lat, rd, pulses);
        do_access(1, 32'h0000_0080, 32'h0, 4'h0, 10, lat, rd, pulses);
        chk("ws3 latency", 32'(lat), 32'd5);
        chk("ws3 pulses", 32'(pulses), 32'd1);
        chk("ws3 rdata", rd, 32'h1111_1111);

        // Abort in WAIT: no ready, no write.
        drive(1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0055, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (if1.mem_ready) cnt++;
        end
        chk("abort no ready", 32'(cnt), 32'd0);
        do_access(1, 32'h0000_0080, 32'h0, 4'h0, 3, lat, rd, pulses);
        chk("abort old data", rd, 32'h1111_1111);
        chk("abort then latency", 32'(lat), 32'd5);

        // Reset landing on the ACCESS cycle abandons the write.
        do_access(1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 3, lat, rd, pulses);
        drive(1, 1'b1, 1'b1, 32'h0000_0040, 32'h7777_7777, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("midreset ready", {31'b0, if1.mem_ready}, 32'h0);
        chk("midreset rdata", if1.mem_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_access(1, 32'h0000_0040, 32'h0, 4'h0, 3, lat, rd, pulses);
        chk("midreset old data", rd, 32'h0BAD_F00D);
        chk("midreset latency", 32'(lat), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
